// File: rtl/sreg_io_pkg.sv
`default_nettype none
// ============================================================================
// sreg_io_pkg : shared FSM state encoding and default chain/phase sizing for
//               the 74165/74595 shift-register I/O sequencer.
// Revision    : 1.0
// ============================================================================
package sreg_io_pkg;

  localparam int unsigned DEF_CHAIN_BITS   = 24;
  localparam int unsigned DEF_PHASE_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH    = 3'd4,
    S_DONE     = 3'd5
  } sreg_state_e;

endpackage
`default_nettype wire

// File: rtl/sreg_phase_timer.sv
`default_nettype none
// ============================================================================
// sreg_phase_timer : strobes phase_end_o on the last clock of every
//                    PHASE_CYCLES-long phase while run_i is high.
// Revision         : 1.0
// ============================================================================
module sreg_phase_timer #(
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic phase_end_o
);

  localparam int unsigned CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end_o = run_i && (cnt_q == LAST_CNT);

  // Every phase transition coincides with the strobe, so clearing on it keeps
  // the count aligned to phase boundaries without a separate restart input.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || phase_end_o) cnt_d = '0;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/sreg_io_sequencer.sv
`default_nettype none
// ============================================================================
// sreg_io_sequencer : full-duplex 74165 (in) / 74595 (out) chain sequencer.
//                     Optional periodic transfers under SREG_AUTO_REFRESH_EN.
// Revision          : 1.0
// ============================================================================
module sreg_io_sequencer
  import sreg_io_pkg::*;
#(
  parameter int unsigned CHAIN_BITS   = DEF_CHAIN_BITS,
  parameter int unsigned PHASE_CYCLES = DEF_PHASE_CYCLES
`ifdef SREG_AUTO_REFRESH_EN
  , parameter int unsigned REFRESH_CYCLES = 1000
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CHAIN_BITS-1:0] out_data,
`ifdef SREG_AUTO_REFRESH_EN
  input  logic                  refresh_en,
`endif
  input  logic                  sdi,
  output logic                  busy,
  output logic                  done,
  output logic [CHAIN_BITS-1:0] in_data,
  output logic                  sclk,
  output logic                  load_n,
  output logic                  latch,
  output logic                  sdo
);

  localparam int unsigned BW = $clog2(CHAIN_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_BITS - 1);

  sreg_state_e           state_q, state_d;
  logic [CHAIN_BITS-1:0] tx_q, tx_d, rx_q, rx_d, in_data_q;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, load_n_q, latch_q, sdo_q, busy_q, done_q;
  logic                  phase_run, phase_end, req, accept;

`ifdef SREG_AUTO_REFRESH_EN
  localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;

  // Saturates at the terminal count so a tick landing mid-transfer fires
  // as soon as the sequencer is idle again.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    if (!refresh_en || accept)   ref_cnt_d = '0;
    else if (ref_cnt_q != REF_LAST) ref_cnt_d = ref_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_cnt_q <= '0;
    else        ref_cnt_q <= ref_cnt_d;
  end

  assign req = start || (refresh_en && (ref_cnt_q == REF_LAST));
`else
  assign req = start;
`endif

  // busy_q lags the state by one clock, so gating on it also rejects a
  // request arriving during the visible done pulse.
  assign accept    = (state_q == S_IDLE) && !busy_q && req;
  assign phase_run = state_q inside {S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH};

  sreg_phase_timer #(
    .PHASE_CYCLES (PHASE_CYCLES)
  ) u_phase_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (phase_run),
    .phase_end_o (phase_end)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_LOAD;
          tx_d      = out_data;
          rx_d      = '0;
          bit_cnt_d = '0;
        end
      end
      S_LOAD:     if (phase_end) state_d = S_SHIFT_LO;
      S_SHIFT_LO: begin
        if (phase_end) begin
          rx_d    = (rx_q << 1) | CHAIN_BITS'(sdi);
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          tx_d      = tx_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == LAST_BIT) ? S_LATCH : S_SHIFT_LO;
        end
      end
      S_LATCH:    if (phase_end) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the current state one clock later, which
  // keeps them free of decode glitches and mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      in_data_q <= '0;
      sclk_q    <= 1'b0;
      load_n_q  <= 1'b1;
      latch_q   <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= (state_q == S_SHIFT_HI);
      load_n_q  <= (state_q != S_LOAD);
      latch_q   <= (state_q == S_LATCH);
      sdo_q     <= tx_q[CHAIN_BITS-1];
      busy_q    <= (state_q != S_IDLE);
      done_q    <= (state_q == S_DONE);
      if (state_q == S_DONE) in_data_q <= rx_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign in_data = in_data_q;
  assign sclk    = sclk_q;
  assign load_n  = load_n_q;
  assign latch   = latch_q;
  assign sdo     = sdo_q;

endmodule
`default_nettype wire

// File: tb/tb_sreg_io_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sreg_io_sequencer : self-checking bench with 74165/74595 chain models.
// Revision             : 1.0
// ============================================================================
module tb_sreg_io_sequencer;

  localparam int N      = 24;
  localparam int P      = 2;
  localparam int LAT_A  = (2 * N + 2) * P + 1;
  localparam int LAT_B  = (2 * 8 + 2) * 1 + 1;

  typedef struct {
    logic [N-1:0] in_v;
    logic [N-1:0] out_v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] out_data = '0;
  logic         sdi;
  logic         busy, done, sclk, load_n, latch, sdo;
  logic [N-1:0] in_data;

  logic         start_b = 1'b0;
  logic [7:0]   out_data_b = '0;
  logic         sdi_b;
  logic         busy_b, done_b, sclk_b, load_n_b, latch_b, sdo_b;
  logic [7:0]   in_data_b;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sreg_io_sequencer #(.CHAIN_BITS(N), .PHASE_CYCLES(P)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .out_data(out_data),
`ifdef SREG_AUTO_REFRESH_EN
    .refresh_en(1'b0),
`endif
    .sdi(sdi), .busy(busy), .done(done), .in_data(in_data),
    .sclk(sclk), .load_n(load_n), .latch(latch), .sdo(sdo)
  );

  sreg_io_sequencer #(.CHAIN_BITS(8), .PHASE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .out_data(out_data_b),
`ifdef SREG_AUTO_REFRESH_EN
    .refresh_en(1'b0),
`endif
    .sdi(sdi_b), .busy(busy_b), .done(done_b), .in_data(in_data_b),
    .sclk(sclk_b), .load_n(load_n_b), .latch(latch_b), .sdo(sdo_b)
  );

  // Chain models, evaluated on the falling edge away from DUT updates.
  logic [N-1:0] in_val = '0, sr165 = '0, sr595 = '0, out595 = '0;
  logic         sclk_p = 1'b0, latch_p = 1'b0;
  int           sclk_rises = 0, latch_rises = 0, done_pulses = 0;
  logic [7:0]   sr595b = '0, out595b = '0;
  logic         sclk_pb = 1'b0, latch_pb = 1'b0;

  assign sdi   = sr165[N-1];
  assign sdi_b = 1'b0;

  always @(negedge clk) begin
    if (load_n == 1'b0)          sr165 <= in_val;
    else if (sclk && !sclk_p)    sr165 <= sr165 << 1;
    if (sclk && !sclk_p) begin
      sr595 <= {sr595[N-2:0], sdo};
      sclk_rises++;
    end
    if (latch && !latch_p) begin
      out595 <= sr595;
      latch_rises++;
    end
    if (done) done_pulses++;
    sclk_p  <= sclk;
    latch_p <= latch;
    if (sclk_b && !sclk_pb)   sr595b  <= {sr595b[6:0], sdo_b};
    if (latch_b && !latch_pb) out595b <= sr595b;
    sclk_pb  <= sclk_b;
    latch_pb <= latch_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transfer on DUT A; poke re-asserts start 10 clocks after accept.
  task automatic run_xfer(input logic [N-1:0] o, input logic [N-1:0] i, input bit poke);
    exp_t e;
    int   lat;
    in_val  = i;
    out_data = o;
    e.in_v  = i;
    e.out_v = o;
    sb.push_back(e);
    start = 1'b1;
    tick(1);
    start    = 1'b0;
    out_data = ~o;
    lat = 0;
    do begin
      tick(1);
      lat++;
      start = poke && (lat == 10);
    end while (!done && lat < 300);
    start = 1'b0;
    e = sb.pop_front();
    check("latency", lat, LAT_A);
    check("in_data", in_data, e.in_v);
    check("out595", out595, e.out_v);
  endtask

  initial begin
    int sc0, lr0, dp0, cyc;

    tick(3);
    check("rst_sclk", sclk, 1'b0);
    check("rst_load_n", load_n, 1'b1);
    check("rst_latch", latch, 1'b0);
    check("rst_sdo", sdo, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_data", in_data, '0);
    rst_n = 1'b1;
    tick(2);

    lr0 = latch_rises;
    run_xfer(24'hA5C3F0, 24'h123456, 1'b0);
    check("latch_once", latch_rises - lr0, 1);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("done_cycle_start_ignored", busy, 1'b0);
    check("in_data_hold", in_data, 24'h123456);

    sc0 = sclk_rises;
    dp0 = done_pulses;
    run_xfer(24'h5A0F96, 24'hFEDCBA, 1'b1);
    tick(5);
    check("one_done_pulse", done_pulses - dp0, 1);
    check("sclk_edges", sclk_rises - sc0, N);
    check("idle_after_poke", busy, 1'b0);

    run_xfer(24'hFFFFFF, 24'h000001, 1'b0);
    tick(2);

    out_data_b = 8'h81;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    cyc = 0;
    do begin
      tick(1);
      cyc++;
    end while (!done_b && cyc < 100);
    check("b_latency", cyc, LAT_B);
    check("b_out595", out595b, 8'h81);
    check("b_in_data", in_data_b, 8'h00);

    tick(2);
    in_val   = 24'h0F0F0F;
    out_data = 24'h333333;
    sc0 = sclk_rises;
    lr0 = latch_rises;
    dp0 = done_pulses;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 0;
    while (!(sclk && (sclk_rises - sc0 == 13)) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("reach_bit13_hi", (cyc < 200), 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_sclk", sclk, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_in_data", in_data, '0);
    tick(1);
    check("rst_mid_sclk", sclk, 1'b0);
    check("rst_mid_load_n", load_n, 1'b1);
    check("rst_mid_latch", latch, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    rst_n = 1'b1;
    tick(150);
    check("no_latch_after_rst", latch_rises - lr0, 0);
    check("no_done_after_rst", done_pulses - dp0, 0);
    check("idle_after_rst", busy, 1'b0);
    check("in_data_after_rst", in_data, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
